ddr_line_sequencer: RTL and testbench

Cache-line sequencer between the cache/memory subsystem and the DDR SRAM-facade adapter. It accepts one line-granular fill (read) or writeback (write) request. It breaks the request into `LINE_WORDS` sequential full-word requests on the adapter's req/ready contract, assembles read words into a line buffer, and returns the whole line with a one-cycle completion pulse. A watchdog aborts a word access that never completes and flags the error.

---
 rtl/ddr_line_sequencer_pkg.sv | 22 ++
 rtl/ddr_line_sequencer_if.sv | 43 ++++
 rtl/ddr_seq_watchdog.sv | 30 +++
 rtl/ddr_line_sequencer.sv | 135 +++++++++++++
 tb/tb_ddr_line_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_line_sequencer_pkg.sv
// Shared types and constants for the DDR line sequencer and its helpers.
// Holds the sequencer state encoding, word geometry and line-offset helper.
// No logic; imported by every file of the block.
package ddr_line_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 27;

    // Number of byte-address bits covered by one cache line.
    function automatic int LINE_OFFSET_BITS(input int line_words);
        return $clog2(line_words * WORD_BYTES);
    endfunction

endpackage

// File: rtl/ddr_line_sequencer_if.sv
// Line-side and adapter-side signal bundle of the DDR line sequencer.
// Pure wiring, no latency.
// master = cache side plus adapter model, slave = the sequencer itself.
interface ddr_line_sequencer_if #(
    parameter int LINE_WORDS = 4
);
    import ddr_line_sequencer_pkg::*;

    // cache/memory subsystem side
    logic                         line_req;
    logic                         line_we;
    logic [ADDR_W-1:0]            line_addr;
    logic [LINE_WORDS*WORD_W-1:0] line_wdata;
    logic [LINE_WORDS*WORD_W-1:0] line_rdata;
    logic                         line_ready;
    logic                         line_error;
    logic                         line_busy;

    // DDR SRAM-facade adapter side
    logic                         mem_req;
    logic                         mem_we;
    logic [3:0]                   mem_be;
    logic [ADDR_W-1:0]            mem_addr;
    logic [WORD_W-1:0]            mem_wdata;
    logic [WORD_W-1:0]            mem_rdata;
    logic                         mem_ready;
    logic                         mem_busy;

    modport master (
        output line_req, line_we, line_addr, line_wdata,
        input  line_rdata, line_ready, line_error, line_busy,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, mem_busy
    );

    modport slave (
        input  line_req, line_we, line_addr, line_wdata,
        output line_rdata, line_ready, line_error, line_busy,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, mem_busy
    );

endinterface

// File: rtl/ddr_seq_watchdog.sv
// Loadable down-counter with a zero flag, used to bound adapter waits.
// Load takes effect on the next edge; zero is combinational from the count.
// No backpressure; counting stops at zero until the next load.
module ddr_seq_watchdog #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    // Load has priority over counting; the count saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/ddr_line_sequencer.sv
// Splits one cache-line fill/writeback into LINE_WORDS word accesses.
// Latency: 1 + sum(per-word adapter latency + 1) cycles, done pulse included.
// Backpressure: word requests held while mem_busy; line_req ignored while busy.
module ddr_line_sequencer
    import ddr_line_sequencer_pkg::*;
#(
    parameter int LINE_WORDS     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    ddr_line_sequencer_if.slave bus
);

    localparam int OFF_BITS = LINE_OFFSET_BITS(LINE_WORDS);
    localparam int IDX_W    = $clog2(LINE_WORDS);
    localparam int WD_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LINE_W   = LINE_WORDS * WORD_W;

    localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFF_BITS) - ADDR_W'(1));
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);
    localparam logic [WD_W-1:0]   WD_LOAD   = WD_W'(TIMEOUT_CYCLES - 1);

    seq_state_t         state, state_nxt;
    logic               we_q;
    logic               err_q;
    logic [ADDR_W-1:0]  base_q;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  buf_q;
    logic [IDX_W-1:0]   idx_q;

    logic accept;
    logic issue;
    logic word_done;
    logic wd_wait;
    logic wd_zero;
    logic timeout;

    assign accept    = (state == ST_IDLE)  && bus.line_req;
    assign issue     = (state == ST_ISSUE) && !bus.mem_busy;
    assign word_done = (state == ST_WAIT)  && bus.mem_ready;
    assign wd_wait   = (state == ST_WAIT)  && !bus.mem_ready;
    assign timeout   = wd_wait && wd_zero;

    ddr_seq_watchdog #(
        .WIDTH(WD_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .load    (issue),
        .en      (wd_wait),
        .load_val(WD_LOAD),
        .zero    (wd_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the line on accept, gather fill words, track the word index and abort flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            idx_q   <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.line_we;
                base_q  <= bus.line_addr & BASE_MASK;
                wdata_q <= bus.line_wdata;
                buf_q   <= '0;
                idx_q   <= '0;
                err_q   <= 1'b0;
            end
            if (word_done) begin
                if (!we_q) begin
                    buf_q[idx_q*WORD_W +: WORD_W] <= bus.mem_rdata;
                end
                if (idx_q != LAST_IDX) begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next state and outputs. Word address/data derive from registers that only
    // change on the way into ISSUE, so they hold their value between requests.
    always_comb begin
        state_nxt       = state;
        bus.mem_req     = issue;
        bus.mem_we      = we_q;
        bus.mem_be      = 4'hF;
        bus.mem_addr    = base_q + (ADDR_W'(idx_q) * ADDR_W'(WORD_BYTES));
        bus.mem_wdata   = we_q ? wdata_q[idx_q*WORD_W +: WORD_W] : '0;
        bus.line_ready  = 1'b0;
        bus.line_error  = 1'b0;
        bus.line_rdata  = '0;
        bus.line_busy   = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (bus.line_req) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!bus.mem_busy) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mem_ready) begin
                    state_nxt = (idx_q == LAST_IDX) ? ST_DONE : ST_ISSUE;
                end else if (wd_zero) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt      = ST_IDLE;
                bus.line_ready = 1'b1;
                bus.line_error = err_q;
                if (!we_q && !err_q) bus.line_rdata = buf_q;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ddr_line_sequencer.sv
// Self-checking bench: one sequencer with the default watchdog, one with a short one.
// Adapter model is a word-addressed memory answering each request after a set delay.
// Line results are checked against that memory and against closed-form latencies.
module tb_ddr_line_sequencer;
    import ddr_line_sequencer_pkg::*;

    localparam int LW = 4;
    localparam int LB = LW * 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          sel;
    logic          line_req;
    logic          line_we;
    logic [26:0]   line_addr;
    logic [LB-1:0] line_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ready;
    logic          mem_busy;

    ddr_line_sequencer_if #(.LINE_WORDS(LW)) ia ();
    ddr_line_sequencer_if #(.LINE_WORDS(LW)) ib ();

    assign ia.line_req   = line_req & ~sel;
    assign ia.line_we    = line_we;
    assign ia.line_addr  = line_addr;
    assign ia.line_wdata = line_wdata;
    assign ia.mem_rdata  = mem_rdata;
    assign ia.mem_ready  = mem_ready;
    assign ia.mem_busy   = mem_busy;
    assign ib.line_req   = line_req & sel;
    assign ib.line_we    = line_we;
    assign ib.line_addr  = line_addr;
    assign ib.line_wdata = line_wdata;
    assign ib.mem_rdata  = mem_rdata;
    assign ib.mem_ready  = mem_ready;
    assign ib.mem_busy   = mem_busy;

    ddr_line_sequencer #(.LINE_WORDS(LW), .TIMEOUT_CYCLES(1024)) dut_a (
        .clk(clk), .rst(rst), .bus(ia)
    );
    ddr_line_sequencer #(.LINE_WORDS(LW), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst), .bus(ib)
    );

    // Observation of whichever sequencer is currently selected.
    wire          o_req   = sel ? ib.mem_req    : ia.mem_req;
    wire          o_we    = sel ? ib.mem_we     : ia.mem_we;
    wire [3:0]    o_be    = sel ? ib.mem_be     : ia.mem_be;
    wire [26:0]   o_addr  = sel ? ib.mem_addr   : ia.mem_addr;
    wire [31:0]   o_wdata = sel ? ib.mem_wdata  : ia.mem_wdata;
    wire          o_ready = sel ? ib.line_ready : ia.line_ready;
    wire          o_err   = sel ? ib.line_error : ia.line_error;
    wire          o_busy  = sel ? ib.line_busy  : ia.line_busy;
    wire [LB-1:0] o_rdata = sel ? ib.line_rdata : ia.line_rdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int lat = 1;
    logic drop_en = 1'b0;
    logic [26:0] drop_addr = '0;

    logic [31:0] mem [logic [26:0]];
    logic [26:0] q_addr [$];
    logic        q_we   [$];
    logic [3:0]  q_be   [$];
    logic [31:0] q_wd   [$];
    int          q_cyc  [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Adapter model: log each request, answer it 'lat' cycles later from the memory.
    initial begin : responder
        int rem;
        logic pend;
        logic [26:0] pa;
        rem = 0; pend = 1'b0; pa = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (o_ready) rdy_cnt++;
            if (o_req && !rst) begin
                q_addr.push_back(o_addr); q_we.push_back(o_we); q_be.push_back(o_be);
                q_wd.push_back(o_wdata); q_cyc.push_back(cyc);
                if (o_we) mem[o_addr] = o_wdata;
                if (!(drop_en && o_addr == drop_addr)) begin
                    pend = 1'b1; rem = lat; pa = o_addr;
                end
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (pend) begin
                rem--;
                if (rem == 0) begin
                    pend = 1'b0;
                    if (!mem.exists(pa)) mem[pa] = $urandom;
                    mem_rdata = mem[pa];
                    mem_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Runs one line transaction; optionally toggles line_req noise while the line is busy.
    task automatic do_line(input logic we, input logic [26:0] addr, input logic [LB-1:0] wd,
                           input int busy_n, input logic noise,
                           output logic [LB-1:0] rd, output logic err, output int s, output int r,
                           output logic busy1, output logic busy_after, output logic rdy_after);
        q_addr.delete(); q_we.delete(); q_be.delete(); q_wd.delete(); q_cyc.delete();
        @(posedge clk); #1;
        line_req = 1'b1; line_we = we; line_addr = addr; line_wdata = wd;
        mem_busy = (busy_n > 0);
        s = cyc;
        @(posedge clk); #1;
        line_req = 1'b0;
        busy1 = o_busy;
        repeat (busy_n) begin @(posedge clk); #1; end
        mem_busy = 1'b0;
        r = -1; rd = '0; err = 1'b0; busy_after = 1'bx; rdy_after = 1'bx;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (o_ready) begin
                r = cyc; rd = o_rdata; err = o_err;
                break;
            end
            if (noise) begin
                line_req = 1'($urandom); line_we = 1'($urandom); line_addr = 27'($urandom);
            end
        end
        line_req = 1'b0;
        if (r < 0) begin
            vectors++; miscompares++;
            $display("FAIL line_done_bound: got no line_ready within 3000 cycles, want a pulse");
        end else begin
            @(posedge clk); #1;
            busy_after = o_busy; rdy_after = o_ready;
        end
    endtask

    task automatic test_reset();
        vectors++; if (o_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", o_req); end
        vectors++; if (o_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", o_we); end
        vectors++; if (o_be !== 4'hF) begin miscompares++; $display("FAIL reset_mem_be: got %h want f", o_be); end
        vectors++; if (o_addr !== 27'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", o_addr); end
        vectors++; if (o_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h want 0", o_wdata); end
        vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL reset_line_ready: got %b want 0", o_ready); end
        vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL reset_line_error: got %b want 0", o_err); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_line_busy: got %b want 0", o_busy); end
        vectors++; if (o_rdata !== '0) begin miscompares++; $display("FAIL reset_line_rdata: got %h want 0", o_rdata); end
    endtask

    task automatic test_fill();
        logic [LB-1:0] rd, expd;
        logic err, b1, ba, ra;
        int s, r;
        mem[27'h1230] = 32'h11111111; mem[27'h1234] = 32'h22222222;
        mem[27'h1238] = 32'h33333333; mem[27'h123C] = 32'h44444444;
        expd = 128'h44444444_33333333_22222222_11111111;
        lat = 26;
        do_line(1'b0, 27'h0001234, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, rd, err, s, r, b1, ba, ra);
        vectors++; if (q_addr.size() != LW) begin miscompares++; $display("FAIL fill_req_count: got %0d want %0d", q_addr.size(), LW); end
        for (int i = 0; i < q_addr.size() && i < LW; i++) begin
            vectors++;
            if (q_addr[i] !== 27'h1230 + 27'(4 * i) || q_we[i] !== 1'b0 || q_be[i] !== 4'hF || q_wd[i] !== 32'h0) begin
                miscompares++;
                $display("FAIL fill_word%0d: got addr %h we %b be %h wd %h want addr %h we 0 be f wd 0",
                         i, q_addr[i], q_we[i], q_be[i], q_wd[i], 27'h1230 + 27'(4 * i));
            end
            if (i > 0) begin
                vectors++;
                if (q_cyc[i] - q_cyc[i-1] != 27) begin miscompares++; $display("FAIL fill_req_spacing%0d: got %0d want 27", i, q_cyc[i] - q_cyc[i-1]); end
            end
        end
        vectors++; if (rd !== expd) begin miscompares++; $display("FAIL fill_rdata: got %h want %h", rd, expd); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL fill_error: got %b want 0", err); end
        vectors++; if (r != s + 109) begin miscompares++; $display("FAIL fill_latency: got %0d want %0d", r - s, 109); end
        vectors++; if (b1 !== 1'b1 || ba !== 1'b0 || ra !== 1'b0) begin
            miscompares++; $display("FAIL fill_busy_pulse: got busy_in %b busy_after %b ready_after %b want 1 0 0", b1, ba, ra);
        end
    endtask

    task automatic test_writeback();
        logic [LB-1:0] rd, wd;
        logic err, b1, ba, ra;
        int s, r;
        wd = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
        lat = 1;
        do_line(1'b1, 27'h7FFFFF0, wd, 0, 1'b0, rd, err, s, r, b1, ba, ra);
        vectors++; if (q_addr.size() != LW) begin miscompares++; $display("FAIL wb_req_count: got %0d want %0d", q_addr.size(), LW); end
        for (int i = 0; i < q_addr.size() && i < LW; i++) begin
            vectors++;
            if (q_addr[i] !== 27'h7FFFFF0 + 27'(4 * i) || q_we[i] !== 1'b1 || q_be[i] !== 4'hF || q_wd[i] !== wd[32*i +: 32]) begin
                miscompares++;
                $display("FAIL wb_word%0d: got addr %h we %b be %h wd %h want addr %h we 1 be f wd %h",
                         i, q_addr[i], q_we[i], q_be[i], q_wd[i], 27'h7FFFFF0 + 27'(4 * i), wd[32*i +: 32]);
            end
        end
        vectors++; if (rd !== '0) begin miscompares++; $display("FAIL wb_rdata: got %h want 0", rd); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL wb_error: got %b want 0", err); end
        vectors++; if (r != s + 9) begin miscompares++; $display("FAIL wb_latency: got %0d want 9", r - s); end
    endtask

    task automatic test_busy();
        logic [LB-1:0] rd;
        logic err, b1, ba, ra;
        int s, r;
        lat = 3;
        do_line(1'b0, 27'h0000200, '0, 5, 1'b0, rd, err, s, r, b1, ba, ra);
        vectors++; if (q_addr.size() != LW) begin miscompares++; $display("FAIL busy_req_count: got %0d want %0d", q_addr.size(), LW); end
        vectors++; if (q_cyc.size() == 0 || q_cyc[0] != s + 6) begin
            miscompares++; $display("FAIL busy_first_req: got cycle %0d want %0d", (q_cyc.size() == 0) ? -1 : q_cyc[0] - s, 6);
        end
        vectors++; if (r != s + 22) begin miscompares++; $display("FAIL busy_latency: got %0d want 22", r - s); end
    endtask

    task automatic test_timeout();
        logic [LB-1:0] rd;
        logic err, b1, ba, ra;
        int s, r;
        sel = 1'b1; lat = 1; drop_en = 1'b1; drop_addr = 27'h0000408;
        do_line(1'b0, 27'h0000400, '0, 0, 1'b0, rd, err, s, r, b1, ba, ra);
        repeat (20) @(posedge clk);
        #1;
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL timeout_error: got %b want 1", err); end
        vectors++; if (rd !== '0) begin miscompares++; $display("FAIL timeout_rdata: got %h want 0", rd); end
        vectors++; if (q_addr.size() != 3) begin miscompares++; $display("FAIL timeout_req_count: got %0d want 3", q_addr.size()); end
        vectors++; if (q_cyc.size() < 3 || r != q_cyc[2] + 17) begin
            miscompares++; $display("FAIL timeout_latency: got %0d want 17", (q_cyc.size() < 3) ? -1 : r - q_cyc[2]);
        end
        vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL timeout_busy_after: got %b want 0", ba); end
        drop_en = 1'b0; sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [LB-1:0] rd, expd;
        logic err, b1, ba, ra;
        int s, r, rc0;
        lat = 6;
        q_addr.delete(); q_we.delete(); q_be.delete(); q_wd.delete(); q_cyc.delete();
        rc0 = rdy_cnt;
        @(posedge clk); #1;
        line_req = 1'b1; line_we = 1'b0; line_addr = 27'h0000800;
        @(posedge clk); #1;
        line_req = 1'b0;
        for (int k = 0; k < 500 && q_addr.size() < 2; k++) @(negedge clk);
        vectors++; if (q_addr.size() < 2) begin miscompares++; $display("FAIL rstmid_word1_req: got %0d requests want 2", q_addr.size()); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        vectors++; if (rdy_cnt != rc0) begin miscompares++; $display("FAIL rstmid_no_ready: got %0d pulses want 0", rdy_cnt - rc0); end
        vectors++; if (q_addr.size() != 2) begin miscompares++; $display("FAIL rstmid_no_more_req: got %0d requests want 2", q_addr.size()); end
        lat = 2;
        expd = '0;
        for (int i = 0; i < LW; i++) begin
            if (!mem.exists(27'h800 + 27'(4 * i))) mem[27'h800 + 27'(4 * i)] = $urandom;
            expd[32*i +: 32] = mem[27'h800 + 27'(4 * i)];
        end
        do_line(1'b0, 27'h0000800, '0, 0, 1'b0, rd, err, s, r, b1, ba, ra);
        vectors++; if (rd !== expd || err !== 1'b0) begin miscompares++; $display("FAIL rstmid_next_line: got %h err %b want %h err 0", rd, err, expd); end
        vectors++; if (r != s + 13) begin miscompares++; $display("FAIL rstmid_next_latency: got %0d want 13", r - s); end
    endtask

    task automatic test_random();
        logic [LB-1:0] rd, wd, expd;
        logic [26:0] addr, base, a;
        logic we, err, b1, ba, ra;
        int s, r, bn;
        for (int n = 0; n < 40; n++) begin
            we   = 1'($urandom);
            addr = 27'($urandom_range(0, 255)) | ((($urandom % 2) == 1) ? 27'h7FFFF00 : 27'h0);
            base = addr & ~27'hF;
            wd   = {$urandom, $urandom, $urandom, $urandom};
            lat  = $urandom_range(1, 6);
            bn   = $urandom_range(0, 3);
            expd = '0;
            if (!we) begin
                for (int i = 0; i < LW; i++) begin
                    a = base + 27'(4 * i);
                    if (!mem.exists(a)) mem[a] = $urandom;
                    expd[32*i +: 32] = mem[a];
                end
            end
            do_line(we, addr, wd, bn, 1'b1, rd, err, s, r, b1, ba, ra);
            vectors++; if (q_addr.size() != LW) begin miscompares++; $display("FAIL rnd%0d_req_count: got %0d want %0d", n, q_addr.size(), LW); end
            for (int i = 0; i < q_addr.size() && i < LW; i++) begin
                vectors++;
                if (q_addr[i] !== base + 27'(4 * i) || q_we[i] !== we || q_be[i] !== 4'hF ||
                    q_wd[i] !== (we ? wd[32*i +: 32] : 32'h0)) begin
                    miscompares++;
                    $display("FAIL rnd%0d_word%0d: got addr %h we %b be %h wd %h want addr %h we %b",
                             n, i, q_addr[i], q_we[i], q_be[i], q_wd[i], base + 27'(4 * i), we);
                end
            end
            vectors++; if (rd !== expd || err !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_line: got %h err %b want %h err 0", n, rd, err, expd); end
            vectors++; if (r != s + 1 + bn + LW * (lat + 1)) begin
                miscompares++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, r - s, 1 + bn + LW * (lat + 1));
            end
            vectors++; if (ba !== 1'b0 || ra !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_after: got busy %b ready %b want 0 0", n, ba, ra); end
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0;
        line_req = 1'b0; line_we = 1'b0; line_addr = '0; line_wdata = '0; mem_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_fill();
        test_writeback();
        test_busy();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
